// File: rtl/ibex_cheri_mem_exc_tracker_pkg.sv
// Shared types for the CHERI memory exception tracker.
// CheriExcWidth : width of the checker's per-request exception vector
// cheri_exc_idx_e : bit index of each exception class inside that vector
// cheri_exc_entry_t : one tracker queue entry
package ibex_cheri_mem_exc_tracker_pkg;

    localparam int unsigned CheriExcWidth = 6;

    typedef enum int unsigned {
        TAG_VIOLATION              = 0,
        SEAL_VIOLATION             = 1,
        PERMIT_LOAD_VIOLATION      = 2,
        PERMIT_STORE_VIOLATION     = 3,
        PERMIT_STORE_CAP_VIOLATION = 4,
        LENGTH_VIOLATION           = 5
    } cheri_exc_idx_e;

    typedef struct packed {
        logic [CheriExcWidth-1:0] exc;        // checker exception vector at grant
        logic                     upper_exc;  // instruction upper-half length violation
        logic                     we;         // request was a store
        logic                     discard;    // flushed: pops normally, reports nothing
    } cheri_exc_entry_t;

endpackage

// File: rtl/ibex_cheri_mem_exc_tracker.sv
// CHERI memory exception tracker.
// Captures the checker's exception vector when a request is granted and replays
// it, in order, alongside the matching response, so several bus transactions
// can be outstanding at once.
//
// Handshake: the address phase completes in any cycle with req_i & gnt_i (the
// requester must keep req_i low while req_block_o is high); a response is
// consumed in any cycle with rvalid_i, one response per granted request, in
// grant order.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_i, gnt_i          address-phase request / grant
//   rvalid_i, err_i       response valid / bus error
//   we_i, exc_i           store flag and exception vector, sampled at grant
//   upper_exc_i           upper-half violation (instruction port only)
//   flush_i               discard reporting of every outstanding entry
//   req_block_o           queue full
//   exc_o, upper_exc_o    exceptions for the current response
//   exc_any_o             any exception for the current response
//   err_o                 bus error for a non-discarded response
//   busy_o                at least one entry outstanding
//   spurious_o            response arrived with nothing outstanding
module ibex_cheri_mem_exc_tracker
    import ibex_cheri_mem_exc_tracker_pkg::*;
#(
    parameter int unsigned NumOutstanding = 2,
    parameter bit          DataMem        = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic                     gnt_i,
    input  logic                     rvalid_i,
    input  logic                     err_i,
    input  logic                     we_i,
    input  logic [CheriExcWidth-1:0] exc_i,
    input  logic                     upper_exc_i,
    input  logic                     flush_i,
    output logic                     req_block_o,
    output logic [CheriExcWidth-1:0] exc_o,
    output logic                     upper_exc_o,
    output logic                     exc_any_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic                     spurious_o
);

    localparam int unsigned    PtrW    = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned    CntW    = $clog2(NumOutstanding + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NumOutstanding);

    cheri_exc_entry_t entries_q [NumOutstanding];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;

    logic             full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             report;
    cheri_exc_entry_t head;
    logic             unused_head_we;

    // Pointers wrap at the queue depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full      = (cnt_q == FullCnt);
    assign not_empty = (cnt_q != '0);
    // A pop in the same cycle does not make room: the push is judged on the
    // registered count only, matching what req_block_o advertised.
    assign push      = req_i & gnt_i & ~full;
    assign pop       = rvalid_i & not_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NumOutstanding; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            // Marking every slot is equivalent to marking the valid ones: an
            // invalid slot is rewritten with discard clear when next pushed.
            if (flush_i) begin
                for (int i = 0; i < NumOutstanding; i++) begin
                    entries_q[i].discard <= 1'b1;
                end
            end
            // Placed after the flush loop so a push in the flush cycle wins
            // and the new entry is not discarded.
            if (push) begin
                entries_q[wr_ptr_q] <= '{exc:       exc_i,
                                         upper_exc: upper_exc_i & ~DataMem,
                                         we:        we_i,
                                         discard:   1'b0};
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    assign head           = entries_q[rd_ptr_q];
    assign unused_head_we = head.we;

    // A flush in the response cycle already suppresses the head.
    assign report      = pop & ~head.discard & ~flush_i;
    assign exc_o       = report ? head.exc : '0;
    assign upper_exc_o = report & head.upper_exc & ~DataMem;
    assign exc_any_o   = (|exc_o) | upper_exc_o;
    assign err_o       = report & err_i;
    assign req_block_o = full;
    assign busy_o      = not_empty;
    assign spurious_o  = rvalid_i & ~not_empty;

`ifndef SYNTHESIS
    // Protocol monitors: report the event and keep running.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(req_i && gnt_i && full))
                else $warning("grant while tracker queue full; request not recorded");
            assert (!(rvalid_i && !not_empty))
                else $warning("response with no request outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_ibex_cheri_mem_exc_tracker.sv
// Bench for ibex_cheri_mem_exc_tracker: a data-port instance (depth 2) and an
// instruction-port instance (depth 3) share request payload inputs and have
// their own grant / response strobes.
module tb_ibex_cheri_mem_exc_tracker;

    localparam logic [5:0] TAG  = 6'h01;
    localparam logic [5:0] SEAL = 6'h02;
    localparam logic [5:0] LEN  = 6'h20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       req = 0, we = 0, upper = 0, err = 0, flush = 0;
    logic [5:0] exc = '0;
    logic       gnt_d = 0, gnt_i = 0, rv_d = 0, rv_i = 0;

    logic       rb_d, up_d, any_d, er_d, busy_d, sp_d;
    logic [5:0] ex_d;
    logic       rb_i, up_i, any_i, er_i, busy_i, sp_i;
    logic [5:0] ex_i;

    ibex_cheri_mem_exc_tracker #(.NumOutstanding(2), .DataMem(1'b1)) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_i(gnt_d), .rvalid_i(rv_d),
        .err_i(err), .we_i(we), .exc_i(exc), .upper_exc_i(upper), .flush_i(flush),
        .req_block_o(rb_d), .exc_o(ex_d), .upper_exc_o(up_d), .exc_any_o(any_d),
        .err_o(er_d), .busy_o(busy_d), .spurious_o(sp_d)
    );

    ibex_cheri_mem_exc_tracker #(.NumOutstanding(3), .DataMem(1'b0)) dut_i (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_i(gnt_i), .rvalid_i(rv_i),
        .err_i(err), .we_i(we), .exc_i(exc), .upper_exc_i(upper), .flush_i(flush),
        .req_block_o(rb_i), .exc_o(ex_i), .upper_exc_o(up_i), .exc_any_o(any_i),
        .err_o(er_i), .busy_o(busy_i), .spurious_o(sp_i)
    );

    // ---------------- scoreboard ----------------
    // Each outstanding request: {discard, upper, exc[5:0]}, oldest first.
    logic [7:0] exp_q_d[$];
    logic [7:0] exp_q_i[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Output bundle: {req_block, exc[5:0], upper, any, err, busy, spurious}
    function automatic logic [11:0] pk(logic rb, logic [5:0] x, logic u, logic a,
                                       logic e, logic b, logic s);
        return {rb, x, u, a, e, b, s};
    endfunction

    function automatic logic [11:0] act_d();
        return {rb_d, ex_d, up_d, any_d, er_d, busy_d, sp_d};
    endfunction

    function automatic logic [11:0] act_i();
        return {rb_i, ex_i, up_i, any_i, er_i, busy_i, sp_i};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int msz(int p);
        return (p == 0) ? exp_q_d.size() : exp_q_i.size();
    endfunction

    // Expected outputs from the outstanding-request list.
    task automatic model_eval(input int p, output logic [11:0] e);
        logic [7:0] q[$];
        logic [7:0] hd;
        logic       rv, ok;
        int         depth;
        if (p == 0) begin
            q = exp_q_d; rv = rv_d; depth = 2;
        end else begin
            q = exp_q_i; rv = rv_i; depth = 3;
        end
        hd = (q.size() > 0) ? q[0] : 8'h00;
        ok = rv && (q.size() > 0) && !hd[7] && !flush;
        e = pk(q.size() == depth, ok ? hd[5:0] : 6'h00, ok && hd[6],
               ok && ((hd[5:0] != 0) || hd[6]), ok && err,
               q.size() != 0, rv && (q.size() == 0));
    endtask

    // Advance the list by one clock using the inputs of the cycle.
    task automatic model_upd(input int p);
        logic [7:0] q[$];
        logic       rv, g;
        int         depth;
        bit         do_push, do_pop;
        if (p == 0) begin
            q = exp_q_d; rv = rv_d; g = gnt_d; depth = 2;
        end else begin
            q = exp_q_i; rv = rv_i; g = gnt_i; depth = 3;
        end
        do_push = req && g && (q.size() < depth);
        do_pop  = rv && (q.size() > 0);
        if (flush) begin
            foreach (q[k]) q[k][7] = 1'b1;
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({1'b0, (p == 1) ? upper : 1'b0, exc});
        if (p == 0) exp_q_d = q;
        else exp_q_i = q;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic r, input logic gd, input logic gi, input logic vd,
                          input logic vi, input logic e, input logic f, input logic [5:0] x,
                          input logic u);
        req = r; gnt_d = gd; gnt_i = gi; rv_d = vd; rv_i = vi;
        err = e; flush = f; exc = x; upper = u; we = r & x[0];
    endtask

    // Called just after a falling edge with inputs applied: checks both
    // instances, then clocks the model across the rising edge.
    task automatic step(input bit use_tbl, input logic [11:0] tbl_exp, input string tag);
        logic [11:0] ed, ei;
        #1;
        model_eval(0, ed);
        model_eval(1, ei);
        chk({tag, ".d"}, act_d(), use_tbl ? tbl_exp : ed);
        chk({tag, ".i"}, act_i(), ei);
        @(posedge clk);
        model_upd(0);
        model_upd(1);
    endtask

    // ---------------- directed vectors (data port) ----------------
    typedef struct {
        logic       req, gnt, rv, err, flush;
        logic [5:0] exc;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic g, input logic v, input logic e,
                       input logic f, input logic [5:0] x, input logic [11:0] ex);
        vec_t t;
        t.req = r; t.gnt = g; t.rv = v; t.err = e; t.flush = f; t.exc = x; t.exp = ex;
        tbl.push_back(t);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        // Single TAG request, response three cycles later.
        add(1, 1, 0, 0, 0, TAG,  pk(0, 0,    0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 1, 0));
        add(0, 0, 1, 0, 0, 0,    pk(0, TAG,  0, 1, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 0, 0));
        // Back-to-back LEN then clean; full until the first response.
        add(1, 1, 0, 0, 0, LEN,  pk(0, 0,    0, 0, 0, 0, 0));
        add(1, 1, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 1, 0));
        add(0, 0, 1, 0, 0, 0,    pk(1, LEN,  0, 1, 0, 1, 0));
        add(0, 0, 1, 0, 0, 0,    pk(0, 0,    0, 0, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 0, 0));
        // Full queue with a same-cycle response and grant: pop only.
        add(1, 1, 0, 0, 0, SEAL, pk(0, 0,    0, 0, 0, 0, 0));
        add(1, 1, 0, 0, 0, TAG,  pk(0, 0,    0, 0, 0, 1, 0));
        add(1, 1, 1, 0, 0, LEN,  pk(1, SEAL, 0, 1, 0, 1, 0));
        add(1, 1, 0, 0, 0, LEN,  pk(0, 0,    0, 0, 0, 1, 0));
        add(0, 0, 1, 0, 0, 0,    pk(1, TAG,  0, 1, 0, 1, 0));
        add(0, 0, 1, 0, 0, 0,    pk(0, LEN,  0, 1, 0, 1, 0));
        add(0, 0, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 0, 0));
        // Flush with the first response; a SEAL granted in a flush cycle survives.
        add(1, 1, 0, 0, 0, TAG,  pk(0, 0,    0, 0, 0, 0, 0));
        add(1, 1, 0, 0, 0, LEN,  pk(0, 0,    0, 0, 0, 1, 0));
        add(0, 0, 1, 1, 1, 0,    pk(1, 0,    0, 0, 0, 1, 0));
        add(1, 1, 0, 0, 1, SEAL, pk(0, 0,    0, 0, 0, 1, 0));
        add(0, 0, 1, 1, 0, 0,    pk(1, 0,    0, 0, 0, 1, 0));
        add(0, 0, 1, 1, 0, 0,    pk(0, SEAL, 0, 1, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 0, 0));
        // Response with nothing outstanding.
        add(0, 0, 1, 1, 0, 0,    pk(0, 0,    0, 0, 0, 0, 1));
        add(0, 0, 0, 0, 0, 0,    pk(0, 0,    0, 0, 0, 0, 0));

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset.d", act_d(), 12'h000);
        chk("reset.i", act_i(), 12'h000);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            set_in(tbl[k].req, tbl[k].gnt, 1'b0, tbl[k].rv, 1'b0, tbl[k].err,
                   tbl[k].flush, tbl[k].exc, 1'b0);
            step(1'b1, tbl[k].exp, $sformatf("vec%0d", k));
        end

        // Upper-half exception: reported on the instruction port only.
        @(negedge clk);
        set_in(1, 1, 1, 0, 0, 0, 0, 6'h00, 1);
        step(1'b0, 12'h000, "upper_push");
        @(negedge clk);
        set_in(0, 0, 0, 1, 1, 0, 0, 6'h00, 0);
        #1;
        chk("upper.i", {11'h0, up_i}, 12'h001);
        chk("any.i", {11'h0, any_i}, 12'h001);
        chk("upper.d", {11'h0, up_d}, 12'h000);
        chk("any.d", {11'h0, any_d}, 12'h000);
        step(1'b0, 12'h000, "upper_pop");

        // Reset with two entries outstanding on the instruction port.
        @(negedge clk);
        set_in(1, 0, 1, 0, 0, 0, 0, LEN, 0);
        step(1'b0, 12'h000, "pre_rst0");
        @(negedge clk);
        set_in(1, 0, 1, 0, 0, 0, 0, LEN, 0);
        step(1'b0, 12'h000, "pre_rst1");
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 6'h00, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.busy_i", {11'h0, busy_i}, 12'h000);
        chk("rst_mid.i", act_i(), 12'h000);
        exp_q_d.delete();
        exp_q_i.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 1, 0, 0, 6'h00, 0);
        #1;
        chk("rst_spur.i", {11'h0, sp_i}, 12'h001);
        step(1'b0, 12'h000, "rst_spur");

        // Randomized traffic against the list model.
        for (int c = 0; c < 800; c++) begin
            logic       r, gd, gi, vd, vi, e, f, u;
            logic [5:0] x;
            @(negedge clk);
            r  = ($urandom_range(0, 9) < 7);
            gd = r && (msz(0) < 2) && ($urandom_range(0, 3) != 0);
            gi = r && (msz(1) < 3) && ($urandom_range(0, 3) != 0);
            vd = (msz(0) > 0) && ($urandom_range(0, 1) == 1);
            vi = (msz(1) > 0) && ($urandom_range(0, 2) == 0);
            e  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 19) == 0);
            u  = ($urandom_range(0, 3) == 0);
            x  = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
            set_in(r, gd, gi, vd, vi, e, f, x, u);
            step(1'b0, 12'h000, $sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
